// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory and its load/store front end.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Request attributes carried alongside the array read until the output stage.
  typedef struct packed {
    logic       v;
    logic       err;
    logic       we;
    logic       uns;
    logic [1:0] size;
    logic [1:0] off;
  } sb_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << off;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_ext = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 RAM: byte-enable synchronous write, registered synchronous read (read-before-write).
module dmem_array #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store front end over dmem_array: handshake, error checks, zero-fill sweep,
// pipelined sideband delay and registered sign/zero-extended response.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 4096,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

  state_t           state, state_nx;
  logic [IDX_W-1:0] clr_idx, clr_idx_nx;
  logic             ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
      ready_q <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    case (state)
      INIT: begin
        clr_idx_nx = clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(DEPTH - 1)) state_nx = RUN;
      end
      RUN:     state_nx = RUN;
      default: state_nx = RST_STATE;
    endcase
  end

  assign req_ready = ready_q;

  // Request decode and error check
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_err;
  logic                  accept;

  assign off      = req_addr[1:0];
  assign word_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};
  assign req_err  = (req_size == 2'd3)
                  | ((req_size == SZ_H) && off[0])
                  | ((req_size == SZ_W) && (off != 2'd0))
                  | (word_idx >= ADDR_WIDTH'(DEPTH));
  assign accept   = req_valid && ready_q;

  // The single array port is owned by the sweep during INIT and by requests in RUN.
  logic [3:0]       arr_we;
  logic [IDX_W-1:0] arr_addr;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;

  always_comb begin
    arr_we    = 4'b0000;
    arr_addr  = req_addr[IDX_W+1:2];
    arr_wdata = req_wdata;
    if (state == INIT) begin
      arr_we    = 4'b1111;
      arr_addr  = clr_idx;
      arr_wdata = '0;
    end else begin
      if (accept && req_we && !req_err) arr_we = lane_mask(req_size, off);
      case (req_size)
        SZ_B:    arr_wdata = {4{req_wdata[7:0]}};
        SZ_H:    arr_wdata = {2{req_wdata[15:0]}};
        default: arr_wdata = req_wdata;
      endcase
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Sideband stage 0 lines up with the array read register; later stages add latency.
  sb_t sb_q [RD_LATENCY];
  sb_t last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) sb_q[k] <= '0;
    end else begin
      sb_q[0] <= '{v: accept, err: req_err, we: req_we, uns: req_unsigned,
                   size: req_size, off: off};
      for (int k = 1; k < RD_LATENCY; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  assign last = sb_q[RD_LATENCY-1];

  logic [31:0] last_word;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign last_word = arr_rdata;
    end else begin : g_latn
      logic [31:0] word_q [RD_LATENCY-1];
      always_ff @(posedge clk) begin
        word_q[0] <= arr_rdata;
        for (int k = 1; k < RD_LATENCY - 1; k++) word_q[k] <= word_q[k-1];
      end
      assign last_word = word_q[RD_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= last.v;
      rsp_err   <= last.v && last.err;
      rsp_rdata <= (last.v && !last.err && !last.we)
                   ? load_ext(last_word, last.size, last.off, last.uns) : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: instance 0 (DEPTH=16, latency 2, zero-fill) and
// instance 1 (DEPTH=16, latency 4, no zero-fill) sharing clock and reset.
module tb_data_mem_lsu;

  localparam int W = 65;  // {err, data[31:0], due_cycle[31:0]}

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  logic [31:0] cyc;
  int          total;
  int          bad;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  data_mem_lsu #(.ADDR_WIDTH(32), .DEPTH(16), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_lsu #(.ADDR_WIDTH(32), .DEPTH(16), .RD_LATENCY(4), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Scoreboard queue helpers
  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W-1:0] q_front(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic logic [W-1:0] q_pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic q_push(input int d, input logic [W-1:0] e);
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic q_flush();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Driver: present a request, wait (bounded) for acceptance, push the expected response.
  task automatic req(input int d, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_err);
    int n;
    logic [31:0] acc;
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    n = 0;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check($sformatf("d%0d_ready_wait", d), {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    q_push(d, {exp_err, exp_data, acc + 32'(lat(d))});
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_size(0) + q_size(1)) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q_size(0) + q_size(1)), 32'd0);
  endtask

  task automatic mon(input int d);
    logic [W-1:0] e;
    if (rsp_valid[d]) begin
      if (q_size(d) == 0) begin
        check($sformatf("d%0d_spurious_rsp", d), {31'b0, rsp_valid[d]}, 32'd0);
      end else begin
        e = q_pop(d);
        check($sformatf("d%0d_rdata", d), rsp_rdata[d], e[63:32]);
        check($sformatf("d%0d_err", d), {31'b0, rsp_err[d]}, {31'b0, e[64]});
        check($sformatf("d%0d_rsp_cycle", d), cyc, e[31:0]);
      end
    end else begin
      check($sformatf("d%0d_idle_rdata", d), rsp_rdata[d], 32'd0);
      check($sformatf("d%0d_idle_err", d), {31'b0, rsp_err[d]}, 32'd0);
      if (q_size(d) != 0) begin
        e = q_front(d);
        if (e[31:0] <= cyc) begin
          check($sformatf("d%0d_missing_rsp", d), {31'b0, rsp_valid[d]}, 32'd1);
          void'(q_pop(d));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  task automatic check_reset_outputs(input int d);
    check($sformatf("d%0d_rst_ready", d), {31'b0, req_ready[d]}, 32'd0);
    check($sformatf("d%0d_rst_valid", d), {31'b0, rsp_valid[d]}, 32'd0);
    check($sformatf("d%0d_rst_rdata", d), rsp_rdata[d], 32'd0);
    check($sformatf("d%0d_rst_err", d), {31'b0, rsp_err[d]}, 32'd0);
  endtask

  task automatic count_init(input string tag);
    int n;
    n = 0;
    while (!req_ready[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'd16);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] dv;
    int k;
    total = 0;
    bad   = 0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);

    // Zero-fill sweep length, then first load of cleared memory
    rst = 1'b0;
    count_init("init_len");
    check("b_ready_run", {31'b0, req_ready[1]}, 32'd1);
    req(0, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);

    // Store word, then sub-word loads with both extensions
    req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8BADF00D, 32'h0, 1'b0);
    req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF8B, 1'b0);
    req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000008B, 1'b0);
    req(0, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFFF00D, 1'b0);
    req(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00008BAD, 1'b0);

    // Byte store immediately followed by a word load of the same word
    req(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005A, 32'h0, 1'b0);
    req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8BAD5A0D, 1'b0);

    // Error cases; the misaligned store must not modify memory
    req(0, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    req(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
    req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8BAD5A0D, 1'b0);
    req(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
    req(0, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
    req(0, 1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b1);

    // Randomised word stores with byte and word read-back
    for (int i = 0; i < 4; i++) begin
      a  = 32'h20 + 32'(4 * $urandom_range(0, 7));
      dv = $urandom();
      k  = $urandom_range(0, 3);
      req(0, 1'b1, 2'd2, 1'b0, a, dv, 32'h0, 1'b0);
      req(0, 1'b0, 2'd0, 1'b1, a + 32'(k), 32'h0, (dv >> (8 * k)) & 32'hFF, 1'b0);
      req(0, 1'b0, 2'd2, 1'b1, a, 32'h0, dv, 1'b0);
    end
    drain();

    // Reset in the middle of the sweep restarts it
    @(negedge clk);
    rst = 1'b1;
    q_flush();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    count_init("init_len_restart");
    req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    drain();

    // Reset with two loads in flight discards their responses
    req(0, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    req(0, 1'b0, 2'd2, 1'b0, 32'h38, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    q_flush();
    repeat (2) begin
      @(negedge clk);
      check("inflight_rst_valid", {31'b0, rsp_valid[0]}, 32'd0);
      check("inflight_rst_rdata", rsp_rdata[0], 32'd0);
      check("inflight_rst_err", {31'b0, rsp_err[0]}, 32'd0);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Latency-4 instance: eight stores, then eight back-to-back loads
    for (int i = 0; i < 8; i++) req(1, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) req(1, 1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0, 32'(i), 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
